// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, derived sync windows and the per-axis phase type.
package vga_timing_pkg;

    localparam int COUNT_W   = 10;
    localparam int COUNT_MAX = 1 << COUNT_W;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    // Final counter value of a phase that begins at 'start' and lasts 'len' counts.
    function automatic logic [COUNT_W-1:0] phase_last(input int start, input int len);
        return COUNT_W'(start + len - 1);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE,
    parameter int FRONT_LEN  = H_FRONT,
    parameter int SYNC_LEN   = H_SYNC,
    parameter int BACK_LEN   = H_BACK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [COUNT_W-1:0] count_next_o,
    output phase_e             phase_o,
    output phase_e             phase_next_o,
    output logic               wrap_o,
    output logic               sync_active_o
);

    localparam logic [COUNT_W-1:0] ACTIVE_END = phase_last(0, ACTIVE_LEN);
    localparam logic [COUNT_W-1:0] FRONT_END  = phase_last(ACTIVE_LEN, FRONT_LEN);
    localparam logic [COUNT_W-1:0] SYNC_END   = phase_last(ACTIVE_LEN + FRONT_LEN, SYNC_LEN);
    localparam logic [COUNT_W-1:0] LAST       = phase_last(ACTIVE_LEN + FRONT_LEN + SYNC_LEN, BACK_LEN);

    logic [COUNT_W-1:0] count_q, count_d;
    phase_e             phase_q, phase_d;
    logic               sync_active_q, sync_active_d;
    logic               wrap;

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        count_d = count_q;
        phase_d = phase_q;
        wrap    = advance_i && (count_q == LAST);

        if (advance_i) begin
            count_d = wrap ? '0 : count_q + COUNT_W'(1);
            case (phase_q)
                PH_ACTIVE: if (count_q == ACTIVE_END) phase_d = PH_FRONT;
                PH_FRONT:  if (count_q == FRONT_END)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == SYNC_END)   phase_d = PH_BACK;
                PH_BACK:   if (count_q == LAST)       phase_d = PH_ACTIVE;
                default:   phase_d = PH_ACTIVE;
            endcase
        end

        // Flag is derived from the next phase so it lines up with the next count.
        sync_active_d = (phase_d == PH_SYNC);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            phase_q       <= PH_ACTIVE;
            sync_active_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            phase_q       <= phase_d;
            sync_active_q <= sync_active_d;
        end
    end

    assign count_o       = count_q;
    assign count_next_o  = count_d;
    assign phase_o       = phase_q;
    assign phase_next_o  = phase_d;
    assign wrap_o        = wrap;
    assign sync_active_o = sync_active_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 Hz scan/sync generator. Define VGA_CLK_DIV2_EN to run from a 50 MHz clk
// with an internal divide-by-two pixel enable; otherwise clk is the 25 MHz pixel clock.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_LEN = H_ACTIVE,
    parameter int H_FRONT_LEN  = H_FRONT,
    parameter int H_SYNC_LEN   = H_SYNC,
    parameter int H_BACK_LEN   = H_BACK,
    parameter int V_ACTIVE_LEN = V_ACTIVE,
    parameter int V_FRONT_LEN  = V_FRONT,
    parameter int V_SYNC_LEN   = V_SYNC,
    parameter int V_BACK_LEN   = V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               video_on,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk,
    output logic               pix_tick,
    output logic               frame_start
);

    // Both frame dimensions must fit the 10-bit unsigned counters.
    if ((H_ACTIVE_LEN + H_FRONT_LEN + H_SYNC_LEN + H_BACK_LEN) > COUNT_MAX ||
        (V_ACTIVE_LEN + V_FRONT_LEN + V_SYNC_LEN + V_BACK_LEN) > COUNT_MAX ||
        H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX ||
        H_SYNC_START < H_ACTIVE || H_SYNC_END >= H_TOTAL ||
        V_SYNC_START < V_ACTIVE || V_SYNC_END >= V_TOTAL) begin : g_bad_timing
        $error("vga_sync_gen: timing does not fit %0d-bit counters", COUNT_W);
    end

    logic               advance;
    logic [COUNT_W-1:0] h_count, h_count_next, v_count, v_count_next;
    phase_e             h_phase, h_phase_next, v_phase, v_phase_next;
    logic               h_wrap, v_wrap, h_sync_active, v_sync_active;
    logic               video_on_q, video_on_d;
    logic               frame_start_q, frame_start_d;

`ifdef VGA_CLK_DIV2_EN
    logic pix_en_q;

    always_ff @(posedge clk) begin
        if (reset) pix_en_q <= 1'b0;
        else       pix_en_q <= ~pix_en_q;
    end

    assign advance  = pix_en_q;
    assign pix_tick = pix_en_q;
    // Rising edge of the DAC clock falls in the middle of each two-clk pixel.
    assign vga_clk  = pix_en_q;
`else
    logic tick_q;

    always_ff @(posedge clk) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= 1'b1;
    end

    assign advance  = 1'b1;
    assign pix_tick = tick_q;
    assign vga_clk  = ~clk;
`endif

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE_LEN),
        .FRONT_LEN  (H_FRONT_LEN),
        .SYNC_LEN   (H_SYNC_LEN),
        .BACK_LEN   (H_BACK_LEN)
    ) u_h_axis (
        .clk           (clk),
        .reset         (reset),
        .advance_i     (advance),
        .count_o       (h_count),
        .count_next_o  (h_count_next),
        .phase_o       (h_phase),
        .phase_next_o  (h_phase_next),
        .wrap_o        (h_wrap),
        .sync_active_o (h_sync_active)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE_LEN),
        .FRONT_LEN  (V_FRONT_LEN),
        .SYNC_LEN   (V_SYNC_LEN),
        .BACK_LEN   (V_BACK_LEN)
    ) u_v_axis (
        .clk           (clk),
        .reset         (reset),
        .advance_i     (h_wrap),
        .count_o       (v_count),
        .count_next_o  (v_count_next),
        .phase_o       (v_phase),
        .phase_next_o  (v_phase_next),
        .wrap_o        (v_wrap),
        .sync_active_o (v_sync_active)
    );

    always_comb begin
        video_on_d    = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
        frame_start_d = (h_count_next == '0) && (v_count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    logic unused_axis;
    assign unused_axis = ^{h_phase, v_phase, v_wrap};

    assign x           = h_count;
    assign y           = v_count;
    assign hsync_n     = ~h_sync_active;
    assign vsync_n     = ~v_sync_active;
    assign video_on    = video_on_q;
    assign vga_blank_n = video_on_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing instance plus a shrunken-timing instance for frame-level events.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } timing_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs_n;
        logic       vs_n;
        logic       vid;
        logic       blank_n;
        logic       sync_n;
        logic       fs;
        logic       tick;
        logic       vclk;
    } snap_t;

`ifdef VGA_CLK_DIV2_EN
    localparam int TPP = 2;
`else
    localparam int TPP = 1;
`endif

    localparam timing_t FULL  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t SMALL = '{40, 4, 8, 4, 30, 3, 2, 5};
    localparam int S_HT    = 56;
    localparam int S_FRAME = 56 * 40;

    logic       clk, reset;
    logic [9:0] f_x, f_y, s_x, s_y;
    logic       f_hsync_n, f_vsync_n, f_video_on, f_blank_n, f_sync_n, f_vga_clk, f_pix_tick, f_frame_start;
    logic       s_hsync_n, s_vsync_n, s_video_on, s_blank_n, s_sync_n, s_vga_clk, s_pix_tick, s_frame_start;

    int t;
    int checks;
    int failures;

    vga_sync_gen u_full (
        .clk (clk), .reset (reset), .x (f_x), .y (f_y),
        .hsync_n (f_hsync_n), .vsync_n (f_vsync_n), .video_on (f_video_on),
        .vga_blank_n (f_blank_n), .vga_sync_n (f_sync_n), .vga_clk (f_vga_clk),
        .pix_tick (f_pix_tick), .frame_start (f_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE_LEN (SMALL.ha), .H_FRONT_LEN (SMALL.hf), .H_SYNC_LEN (SMALL.hs), .H_BACK_LEN (SMALL.hb),
        .V_ACTIVE_LEN (SMALL.va), .V_FRONT_LEN (SMALL.vf), .V_SYNC_LEN (SMALL.vs), .V_BACK_LEN (SMALL.vb)
    ) u_small (
        .clk (clk), .reset (reset), .x (s_x), .y (s_y),
        .hsync_n (s_hsync_n), .vsync_n (s_vsync_n), .video_on (s_video_on),
        .vga_blank_n (s_blank_n), .vga_sync_n (s_sync_n), .vga_clk (s_vga_clk),
        .pix_tick (s_pix_tick), .frame_start (s_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the raster position is simply the number of pixel periods since reset, modulo the frame.
    function automatic snap_t model(input timing_t tm, input int tt);
        snap_t s;
        int ht, vt, n, px, py;
        ht = tm.ha + tm.hf + tm.hs + tm.hb;
        vt = tm.va + tm.vf + tm.vs + tm.vb;
        n  = (tt / TPP) % (ht * vt);
        px = n % ht;
        py = n / ht;
        s.x       = 10'(px);
        s.y       = 10'(py);
        s.hs_n    = !(px >= tm.ha + tm.hf && px < tm.ha + tm.hf + tm.hs);
        s.vs_n    = !(py >= tm.va + tm.vf && py < tm.va + tm.vf + tm.vs);
        s.vid     = (px < tm.ha) && (py < tm.va);
        s.blank_n = s.vid;
        s.sync_n  = 1'b0;
        s.fs      = (n == 0);
        s.tick    = (TPP == 2) ? (tt % 2 == 1) : (tt >= 1);
        s.vclk    = (TPP == 2) ? (tt % 2 == 1) : 1'b0;
        return s;
    endfunction

    function automatic snap_t obs_full();
        snap_t s;
        s.x = f_x; s.y = f_y; s.hs_n = f_hsync_n; s.vs_n = f_vsync_n; s.vid = f_video_on;
        s.blank_n = f_blank_n; s.sync_n = f_sync_n; s.fs = f_frame_start; s.tick = f_pix_tick; s.vclk = f_vga_clk;
        return s;
    endfunction

    function automatic snap_t obs_small();
        snap_t s;
        s.x = s_x; s.y = s_y; s.hs_n = s_hsync_n; s.vs_n = s_vsync_n; s.vid = s_video_on;
        s.blank_n = s_blank_n; s.sync_n = s_sync_n; s.fs = s_frame_start; s.tick = s_pix_tick; s.vclk = s_vga_clk;
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.x = 10'd0; s.y = 10'd0; s.hs_n = 1'b1; s.vs_n = 1'b1; s.vid = 1'b1;
        s.blank_n = 1'b1; s.sync_n = 1'b0; s.fs = 1'b1; s.tick = 1'b0; s.vclk = 1'b0;
        return s;
    endfunction

    // Advance one clk and sample 1 ns after the edge; t counts edges since reset was last seen.
    task automatic step();
        logic rst_seen;
        rst_seen = reset;
        @(posedge clk);
        #1;
        if (rst_seen) t = 0;
        else          t++;
    endtask

    task automatic test_reset();
        snap_t got, exp;
        reset = 1'b1;
        repeat (3) step();
        exp = reset_snap();
        got = obs_full();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_full got=%p exp=%p", got, exp);
        end
        got = obs_small();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_small got=%p exp=%p", got, exp);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_lines();
        snap_t got, exp;
        int hs_low, vid_fall_x, hs_fall_x, hs_rise_x;
        logic prev_vid, prev_hs;
        hs_low = 0; vid_fall_x = -1; hs_fall_x = -1; hs_rise_x = -1;
        prev_vid = f_video_on; prev_hs = f_hsync_n;
        for (int i = 0; i < 3 * 800 * TPP; i++) begin
            step();
            exp = model(FULL, t); got = obs_full();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL scan_full t=%0d got=%p exp=%p", t, got, exp);
            end
            exp = model(SMALL, t); got = obs_small();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL scan_small t=%0d got=%p exp=%p", t, got, exp);
            end
            if (t == TPP) begin
                checks++;
                if (f_x !== 10'd1 || f_y !== 10'd0) begin
                    failures++;
                    $display("FAIL first_tick x=%0d y=%0d exp x=1 y=0", f_x, f_y);
                end
            end
            if (t == 800 * TPP) begin
                checks++;
                if (f_x !== 10'd0 || f_y !== 10'd1 || f_hsync_n !== 1'b1) begin
                    failures++;
                    $display("FAIL line_wrap x=%0d y=%0d hs_n=%b exp x=0 y=1 hs_n=1", f_x, f_y, f_hsync_n);
                end
            end
            if (t <= 800 * TPP) begin
                if (f_hsync_n === 1'b0) hs_low++;
                if (prev_vid === 1'b1 && f_video_on === 1'b0 && vid_fall_x < 0) vid_fall_x = int'(f_x);
                if (prev_hs === 1'b1 && f_hsync_n === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(f_x);
                if (prev_hs === 1'b0 && f_hsync_n === 1'b1 && hs_rise_x < 0) hs_rise_x = int'(f_x);
            end
            prev_vid = f_video_on; prev_hs = f_hsync_n;
        end
        checks++;
        if (hs_low != 96 * TPP) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=%0d", hs_low, 96 * TPP);
        end
        checks++;
        if (vid_fall_x != 640 || hs_fall_x != 656 || hs_rise_x != 752) begin
            failures++;
            $display("FAIL h_edges vid_fall=%0d hs_fall=%0d hs_rise=%0d exp 640 656 752", vid_fall_x, hs_fall_x, hs_rise_x);
        end
    endtask

    task automatic test_frame();
        snap_t got, exp;
        int r1, r2, fs_len, vs_low, budget;
        logic prev_fs;
        r1 = -1; r2 = -1; fs_len = 0; vs_low = 0;
        prev_fs = s_frame_start;
        budget = 3 * S_FRAME * TPP;
        while (r2 < 0 && budget > 0) begin
            step();
            budget--;
            exp = model(SMALL, t); got = obs_small();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL frame_small t=%0d got=%p exp=%p", t, got, exp);
            end
            if (prev_fs === 1'b0 && s_frame_start === 1'b1) begin
                if (r1 < 0) r1 = t;
                else        r2 = t;
            end
            if (r1 >= 0 && r2 < 0) begin
                if (s_vsync_n === 1'b0) vs_low++;
                if (s_frame_start === 1'b1 && t - r1 < 4 * TPP) fs_len++;
            end
            prev_fs = s_frame_start;
        end
        checks++;
        if (r2 < 0) begin
            failures++;
            $display("FAIL frame_timeout got no second frame_start rise, exp one within %0d clks", 3 * S_FRAME * TPP);
        end else if (r2 - r1 != S_FRAME * TPP) begin
            failures++;
            $display("FAIL frame_period got=%0d exp=%0d", r2 - r1, S_FRAME * TPP);
        end
        checks++;
        if (vs_low != SMALL.vs * S_HT * TPP) begin
            failures++;
            $display("FAIL vsync_width got=%0d exp=%0d", vs_low, SMALL.vs * S_HT * TPP);
        end
        checks++;
        if (fs_len != TPP) begin
            failures++;
            $display("FAIL frame_start_len got=%0d exp=%0d", fs_len, TPP);
        end
    endtask

    task automatic test_mid_reset();
        snap_t got, exp;
        int run, hold, s_wrap_t, f_wrap_t;
        run  = int'($urandom_range(50, S_FRAME * TPP));
        hold = int'($urandom_range(1, 3));
        for (int i = 0; i < run; i++) begin
            step();
            exp = model(SMALL, t); got = obs_small();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pre_reset_small t=%0d got=%p exp=%p", t, got, exp);
            end
        end
        reset = 1'b1;
        repeat (hold) step();
        exp = reset_snap();
        got = obs_small();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_small got=%p exp=%p", got, exp);
        end
        got = obs_full();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_full got=%p exp=%p", got, exp);
        end
        reset = 1'b0;
        s_wrap_t = -1; f_wrap_t = -1;
        for (int i = 0; i < 810 * TPP; i++) begin
            step();
            exp = model(FULL, t); got = obs_full();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset_full t=%0d got=%p exp=%p", t, got, exp);
            end
            exp = model(SMALL, t); got = obs_small();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset_small t=%0d got=%p exp=%p", t, got, exp);
            end
            if (s_wrap_t < 0 && s_y === 10'd1 && s_x === 10'd0) s_wrap_t = t;
            if (f_wrap_t < 0 && f_y === 10'd1 && f_x === 10'd0) f_wrap_t = t;
        end
        checks++;
        if (s_wrap_t != S_HT * TPP || f_wrap_t != 800 * TPP) begin
            failures++;
            $display("FAIL reset_line_wrap small=%0d full=%0d exp %0d %0d", s_wrap_t, f_wrap_t, S_HT * TPP, 800 * TPP);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        t        = 0;
        reset    = 1'b1;
        test_reset();
        test_first_lines();
        test_frame();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
